// File: rtl/demux_burst_scheduler.sv
// demux_burst_scheduler: splits one feature-word stream into two lanes in
// alternating fixed-size bursts, one registered output slot per lane, and
// pulses done once a programmed frame has been fully delivered and drained.
module demux_burst_scheduler #(
  parameter int BITS  = 16,
  parameter int BURST = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  output logic             busy,
  output logic             done,
  output logic             sel,
  input  logic [BITS-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BITS-1:0]  out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [BITS-1:0]  out2_data,
  output logic             out2_valid,
  input  logic             out2_ready
);

  // Burst counter only needs to reach BURST-1; keep at least one bit so BURST=1 builds.
  localparam int BURST_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   frame_len_q;
  logic [CNT_W-1:0]   word_cnt_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic               sel_q;
  logic               done_q, done_d;
  logic [BITS-1:0]    out1_data_q, out2_data_q;
  logic               out1_valid_q, out2_valid_q;

  logic launch;      // accepted start with a non-empty frame
  logic accept;      // input word transferred this cycle
  logic last_word;   // the word being accepted completes the frame
  logic burst_last;  // the word being accepted completes the current burst
  logic load1, load2;

  assign launch     = (state_q == IDLE) && start && (frame_len != '0);
  assign last_word  = (word_cnt_q == (frame_len_q - 1'b1));
  assign burst_last = (burst_cnt_q == BURST_LAST);
  assign accept     = in_valid && in_ready;
  assign load1      = accept && !sel_q;
  assign load2      = accept &&  sel_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment uses <= so all registers update from pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, input handshake and done-request decode.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d  = state_q;
    in_ready = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) state_d = RUN;
        else if (start)                 done_d  = 1'b1;
      end
      RUN: begin
        // Ready looks through the selected lane's slot so a draining slot can be refilled every cycle.
        in_ready = sel_q ? (!out2_valid_q || out2_ready) : (!out1_valid_q || out1_ready);
        if (in_valid && in_ready && last_word) state_d = DRAIN;
      end
      DRAIN: begin
        if (!out1_valid_q && !out2_valid_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame bookkeeping: length latch, word/burst counters, lane select, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_len_q <= '0;
      word_cnt_q  <= '0;
      burst_cnt_q <= '0;
      sel_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_d;
      if (launch) begin
        frame_len_q <= frame_len;
        word_cnt_q  <= '0;
        burst_cnt_q <= '0;
        sel_q       <= 1'b0;
      end else if (accept) begin
        word_cnt_q <= word_cnt_q + 1'b1;
        if (burst_last) begin
          burst_cnt_q <= '0;
          sel_q       <= ~sel_q;
        end else begin
          burst_cnt_q <= burst_cnt_q + 1'b1;
        end
      end
    end
  end

  // Lane 1 output slot: load on accept while selected, otherwise empty when the consumer takes it.
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, because the outputs must read zero after reset.
    if (rst) begin
      out1_data_q  <= '0;
      out1_valid_q <= 1'b0;
    end else if (load1) begin
      out1_data_q  <= in_data;
      out1_valid_q <= 1'b1;
    end else if (out1_ready) begin
      out1_valid_q <= 1'b0;
    end
  end

  // Lane 2 output slot: same behaviour as lane 1, driven while sel is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out2_data_q  <= '0;
      out2_valid_q <= 1'b0;
    end else if (load2) begin
      out2_data_q  <= in_data;
      out2_valid_q <= 1'b1;
    end else if (out2_ready) begin
      out2_valid_q <= 1'b0;
    end
  end

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = done_q;
  assign sel        = sel_q;
  assign out1_data  = out1_data_q;
  assign out1_valid = out1_valid_q;
  assign out2_data  = out2_data_q;
  assign out2_valid = out2_valid_q;

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Randomized bench for demux_burst_scheduler: per-lane expected queues are built
// from the burst rule (word i goes to lane (i / BURST) mod 2) and compared against
// every output handshake; a second instance covers the BURST=1 build.
module tb_demux_burst_scheduler;
  localparam int BITS  = 16;
  localparam int BURST = 9;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start;
  logic [CNT_W-1:0] frame_len;
  logic             busy, done, sel;
  logic [BITS-1:0]  in_data;
  logic             in_valid, in_ready;
  logic [BITS-1:0]  out1_data, out2_data;
  logic             out1_valid, out2_valid;
  logic             out1_ready, out2_ready;

  logic             start_b;
  logic [CNT_W-1:0] frame_len_b;
  logic             busy_b, done_b, sel_b;
  logic [BITS-1:0]  in_data_b;
  logic             in_valid_b, in_ready_b;
  logic [BITS-1:0]  out1_data_b, out2_data_b;
  logic             out1_valid_b, out2_valid_b;

  demux_burst_scheduler #(.BITS(BITS), .BURST(BURST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready)
  );

  demux_burst_scheduler #(.BITS(BITS), .BURST(1), .CNT_W(CNT_W)) dut_b1 (
    .clk(clk), .rst(rst), .start(start_b), .frame_len(frame_len_b),
    .busy(busy_b), .done(done_b), .sel(sel_b),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out1_data(out1_data_b), .out1_valid(out1_valid_b), .out1_ready(1'b1),
    .out2_data(out2_data_b), .out2_valid(out2_valid_b), .out2_ready(1'b1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [BITS-1:0] frame_q[$];

  // Drive one frame from frame_q. mode 0: full rate, both ready; mode 1: random
  // valid/ready; mode 2: full rate with lane 1 ready held low for 5 cycles.
  task automatic run_frame(input int len, input int mode, input bit inject_start);
    logic [BITS-1:0] q1[$];
    logic [BITS-1:0] q2[$];
    int idx = 0, cyc = 0, done_cnt = 0, last_acc = -1, done_cyc = -1;
    logic exp_sel;
    for (int i = 0; i < len; i++) begin
      if (((i / BURST) % 2) == 0) q1.push_back(frame_q[i]);
      else                        q2.push_back(frame_q[i]);
    end
    exp_sel = ((len / BURST) % 2) != 0;

    start = 1'b1; frame_len = CNT_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 3000 && done_cnt == 0) begin
      in_valid   = (idx < len) && (mode != 1 || $urandom_range(0, 3) != 0);
      in_data    = (idx < len) ? frame_q[idx] : BITS'($urandom);
      out1_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : ((mode == 2) ? !(cyc >= 3 && cyc < 8) : 1'b1);
      out2_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (inject_start && cyc == 5) begin start = 1'b1; frame_len = 16'd3; end
      else start = 1'b0;
      #1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy low at done", busy, 0);
        check("sel at done", sel, exp_sel);
        check("words accepted", idx, len);
        check("lane1 leftovers", q1.size(), 0);
        check("lane2 leftovers", q2.size(), 0);
        check("out valids at done", {out1_valid, out2_valid}, 0);
      end
      if (mode == 0 && in_valid) check("in_ready full rate", in_ready, 1);
      if (mode == 2 && in_valid && busy && !sel && out1_valid && !out1_ready)
        check("in_ready blocked by lane1", in_ready, 0);
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("lane1 extra word", out1_data, 32'hDEAD_0001);
        else                check("lane1 data", out1_data, q1.pop_front());
      end
      if (out2_valid && out2_ready) begin
        if (q2.size() == 0) check("lane2 extra word", out2_data, 32'hDEAD_0002);
        else                check("lane2 data", out2_data, q2.pop_front());
      end
      if (in_valid && in_ready) begin
        idx++;
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
    check("done seen", done_cnt, 1);
    if (mode == 0 && done_cnt == 1) check("done latency", done_cyc - last_acc, 3);
    for (int k = 0; k < 2; k++) begin
      check("done single pulse", done, 0);
      check("idle after frame", busy, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [BITS-1:0] r1[$];
    logic [BITS-1:0] r2[$];
    logic [BITS-1:0] dat_b[5];
    int len, k, dcnt;

    rst = 1'b1; start = 1'b0; frame_len = '0; in_data = '0; in_valid = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    start_b = 1'b0; frame_len_b = '0; in_data_b = '0; in_valid_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sel", sel, 0);
    check("reset in_ready", in_ready, 0);
    check("reset out valids", {out1_valid, out2_valid}, 0);
    check("reset out data", {out1_data, out2_data}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-frame after 4 words of a 20-word frame.
    start = 1'b1; frame_len = 16'd20;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      in_valid = 1'b1; in_data = BITS'(k + 1);
      #1;
      if (in_ready) k++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset sel", sel, 0);
    check("midreset in_ready", in_ready, 0);
    check("midreset valids", {out1_valid, out2_valid}, 0);
    check("midreset data", {out1_data, out2_data}, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("no done after reset", done, 0);
    end

    // Basic split: 18 words, data 1..18, full rate.
    frame_q.delete();
    for (int i = 0; i < 18; i++) frame_q.push_back(BITS'(i + 1));
    run_frame(18, 0, 1'b0);

    // Partial burst with zero and all-ones words.
    frame_q.delete();
    for (int i = 0; i < 12; i++) frame_q.push_back(BITS'($urandom));
    frame_q[2] = 16'h0000; frame_q[7] = 16'hFFFF; frame_q[10] = 16'h0000; frame_q[11] = 16'hFFFF;
    run_frame(12, 0, 1'b0);

    // Backpressure on lane 1 during the first burst.
    frame_q.delete();
    for (int i = 0; i < 18; i++) frame_q.push_back(BITS'($urandom));
    run_frame(18, 2, 1'b0);

    // Zero-length start: done next cycle, busy never rises.
    start = 1'b1; frame_len = '0;
    #1;
    check("zero len busy before", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("zero len done", done, 1);
    check("zero len busy", busy, 0);
    @(posedge clk); #1;
    check("zero len done pulse", done, 0);
    check("zero len busy after", busy, 0);

    // Ignored start during RUN (random handshakes).
    frame_q.delete();
    for (int i = 0; i < 25; i++) frame_q.push_back(BITS'($urandom));
    run_frame(25, 1, 1'b1);

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 40);
      frame_q.delete();
      for (int i = 0; i < len; i++) frame_q.push_back(BITS'($urandom));
      run_frame(len, 1, 1'b0);
    end

    // A frame after all of the above still starts on lane 1.
    frame_q.delete();
    for (int i = 0; i < 10; i++) frame_q.push_back(BITS'($urandom));
    run_frame(10, 0, 1'b0);

    // BURST=1 instance: A..E alternate lanes every word.
    dat_b[0] = 16'h000A; dat_b[1] = 16'h000B; dat_b[2] = 16'h000C;
    dat_b[3] = 16'h000D; dat_b[4] = 16'h000E;
    start_b = 1'b1; frame_len_b = 16'd5;
    @(posedge clk); #1;
    start_b = 1'b0;
    k = 0; dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid_b = (k < 5);
      in_data_b  = (k < 5) ? dat_b[k] : 16'h0;
      #1;
      if (out1_valid_b) r1.push_back(out1_data_b);
      if (out2_valid_b) r2.push_back(out2_data_b);
      if (done_b) dcnt++;
      if (in_valid_b && in_ready_b) k++;
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    check("b1 lane1 count", r1.size(), 3);
    check("b1 lane2 count", r2.size(), 2);
    if (r1.size() == 3) begin
      check("b1 lane1 w0", r1[0], 16'h000A);
      check("b1 lane1 w1", r1[1], 16'h000C);
      check("b1 lane1 w2", r1[2], 16'h000E);
    end
    if (r2.size() == 2) begin
      check("b1 lane2 w0", r2[0], 16'h000B);
      check("b1 lane2 w1", r2[1], 16'h000D);
    end
    check("b1 done count", dcnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
